reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Register file for the single-issue datapath, with 32 registers of 32 bits each.
- Consumes the 5-bit write-register address produced by the destination-select mux; this block is the write/read end of that address path.
- Adds write-to-read bypass and a pending-write scoreboard, so the decode stage can stall on RAW hazards against writes not yet retired.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; the file holds 2**AW entries.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- RA1  input  AW  read address, port 1.
- RA2  input  AW  read address, port 2.
- RD1  output  DW  read data, port 1.
- RD2  output  DW  read data, port 2.
- IssueEn  input  1  an instruction with a destination register issues this cycle.
- IssueAddr  input  AW  destination register of the issuing instruction (from dest-select mux).
- WE  input  1  write-back enable.
- WA  input  AW  write-back address.
- WD  input  DW  write-back data.
- Stall  output  1  RA1 or RA2 hits a pending, unbypassed write.
- Busy  output  2**AW  scoreboard bit vector, for debug and verification.

Behaviour:
- Reset (Rst=0, asynchronous): all registers clear to 0 and Busy clears to 0. Therefore RD1=RD2=0 and Stall=0 during reset. Reset mid-operation discards all pending writes.
- Register 0 is hardwired to 0:
  - Writes to address 0 are ignored.
  - IssueEn with IssueAddr=0 never sets Busy[0].
  - Reads of address 0 return 0 and never stall.
- Reads are combinational:
  - RDn = (WE && WA==RAn && RAn!=0) ? WD : reg[RAn].
  - The bypass makes same-cycle write-then-read visible with zero latency.
- Writes: on a rising Clk with WE=1 and WA!=0, reg[WA] <= WD. Data is visible from the array on the next cycle, and through the bypass in the same cycle.
- Scoreboard, per address a (a!=0), on each rising Clk:
  - set = IssueEn && IssueAddr==a; clr = WE && WA==a.
  - set && !clr -> Busy[a]=1.
  - clr && !set -> Busy[a]=0.
  - set && clr -> Busy[a]=1. The new issue supersedes the retiring write.
  - Neither -> Busy[a] holds.
  - A write to an address whose Busy bit is 0 is legal; the data is written and Busy stays 0.
- Stall is combinational:
  - Stall = hit(RA1) | hit(RA2).
  - hit(x) = x!=0 && Busy[x] && !(WE && WA==x).
  - A pending write that retires this cycle is bypassed, so it does not stall.
- Stall is advisory only:
  - The block never blocks IssueEn or WE.
  - The upstream stage must deassert IssueEn while Stall=1.
- Only one write-back per cycle. Multiple in-flight issues to the same address keep Busy=1 until the first write-back clears it. Ordering across multiple in-flight writes to one address is the pipeline's responsibility (in-order retire).
- There are no X outputs after reset; all outputs are defined every cycle.

Decomposition:
- Shared package holds:
  - REG_ZERO = 0.
  - DW/AW defaults.
  - A reg-address type of width AW.
- One natural sub-module: sb_scoreboard, which holds the Busy vector with set/clear/priority logic and the hit function.
- The storage array, bypass and read muxes stay in reg_file_sb.

Test Plan:
- Reset with Rst=0 mid-stream after writing reg[3]=32'hDEAD_BEEF -> RD1(RA1=3)=0, Busy=0, Stall=0 immediately (asynchronous).
- WE=1, WA=0, WD=32'hFFFF_FFFF, then read RA1=0 -> RD1=0 both in the same cycle and the next cycle.
- WE=1, WA=7, WD=32'h1234_5678 with RA2=7 in the same cycle -> RD2=32'h1234_5678 in that cycle (bypass), and also on the next cycle from the array.
- IssueEn, IssueAddr=9; next cycle RA1=9 -> Stall=1, Busy[9]=1. Then WE, WA=9, WD=5 in the same cycle as RA1=9 -> Stall=0, RD1=5. Following cycle Busy[9]=0.
- Same-cycle IssueEn IssueAddr=4 and WE WA=4 with Busy[4]=1 -> Busy[4] remains 1; RA1=4 the next cycle gives Stall=1.
- IssueEn IssueAddr=0 -> Busy stays 0; RA1=RA2=0 -> Stall=0, RD1=RD2=0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the reg_file_sb register file slice.
//   DW_DEF / AW_DEF : default data and address widths
//   REG_ZERO        : index of the hardwired-zero register
//   reg_addr_t      : register-address type at the default width
package reg_file_sb_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_if.sv
// Datapath-side bus of the register file: two read ports, the issue
// (scoreboard set) port and the write-back port, plus stall/busy status.
//   master : decode/write-back side, drives addresses, issue and write-back
//   slave  : register file, returns read data, Stall and the Busy vector
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic [AW-1:0]        RA1;
  logic [AW-1:0]        RA2;
  logic [DW-1:0]        RD1;
  logic [DW-1:0]        RD2;
  logic                 IssueEn;
  logic [AW-1:0]        IssueAddr;
  logic                 WE;
  logic [AW-1:0]        WA;
  logic [DW-1:0]        WD;
  logic                 Stall;
  logic [(1<<AW)-1:0]   Busy;

  modport master (
    output RA1, RA2, IssueEn, IssueAddr, WE, WA, WD,
    input  RD1, RD2, Stall, Busy
  );

  modport slave (
    input  RA1, RA2, IssueEn, IssueAddr, WE, WA, WD,
    output RD1, RD2, Stall, Busy
  );

endinterface : reg_file_sb_if

// File: rtl/reg_file_sb_sb_scoreboard.sv
// Pending-write scoreboard. One Busy bit per register (bit 0 never set).
// An issue sets the bit, a write-back clears it; an issue in the same
// cycle as a write-back to that register wins, since the new instruction
// is still in flight. Stall flags a read of a busy register whose value
// is not being bypassed from this cycle's write-back.
//   Clk, Rst      : clock, asynchronous active-low reset
//   i_issue_en/_addr : issuing instruction's destination
//   i_we / i_wa   : write-back enable and address
//   i_ra1 / i_ra2 : read addresses to check for hazards
//   o_busy        : scoreboard vector
//   o_stall       : RAW hazard on either read port
module sb_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                i_issue_en,
  input  logic [AW-1:0]       i_issue_addr,
  input  logic                i_we,
  input  logic [AW-1:0]       i_wa,
  input  logic [AW-1:0]       i_ra1,
  input  logic [AW-1:0]       i_ra2,
  output logic [(1<<AW)-1:0]  o_busy,
  output logic                o_stall
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  function automatic logic hit(input logic [AW-1:0] x,
                               input logic [NREG-1:0] busy,
                               input logic we,
                               input logic [AW-1:0] wa);
    return (x != AW'(REG_ZERO)) && busy[x] && !(we && (wa == x));
  endfunction

  // NOTE: always_comb starts from a full default so no path leaves a bit
  // unassigned; that is what keeps this logic free of inferred latches.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int a = 1; a < NREG; a++) begin
      if (i_issue_en && (i_issue_addr == AW'(a)))
        w_busy_nxt[a] = 1'b1;
      else if (i_we && (i_wa == AW'(a)))
        w_busy_nxt[a] = 1'b0;
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; the async reset lives in the sensitivity list.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  assign o_busy  = r_busy;
  assign o_stall = hit(i_ra1, r_busy, i_we, i_wa) |
                   hit(i_ra2, r_busy, i_we, i_wa);

endmodule : sb_scoreboard

// File: rtl/reg_file_sb.sv
// 2**AW x DW register file with write-to-read bypass and a pending-write
// scoreboard for RAW-hazard stalls. Register 0 reads as zero and ignores
// writes. Reads are combinational; the write port commits on rising Clk.
//   Clk  : rising-edge clock
//   Rst  : asynchronous active-low reset (clears array and scoreboard)
//   bus  : reg_file_sb_if slave (read ports, issue, write-back, status)
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  reg_file_sb_if.slave  bus
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   r_regs [NREG];
  logic [DW-1:0]   w_rd1;
  logic [DW-1:0]   w_rd2;
  logic [NREG-1:0] w_busy;
  logic            w_stall;
  logic            w_wr_ok;

  assign w_wr_ok = bus.WE && (bus.WA != AW'(REG_ZERO));

  // NOTE: the array is reset like ordinary flops because reset must clear
  // every register; this file is flop-based, not a RAM macro.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)         r_regs <= '{default: '0};
    else if (w_wr_ok) r_regs[bus.WA] <= bus.WD;
  end

  // Bypass is qualified with Rst so reads are 0 throughout reset even if
  // the write-back port is still active.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (bus.RA1 != AW'(REG_ZERO))
      w_rd1 = (Rst && bus.WE && (bus.WA == bus.RA1)) ? bus.WD : r_regs[bus.RA1];
    if (bus.RA2 != AW'(REG_ZERO))
      w_rd2 = (Rst && bus.WE && (bus.WA == bus.RA2)) ? bus.WD : r_regs[bus.RA2];
  end

  sb_scoreboard #(.AW(AW)) u_sb (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_issue_en   (bus.IssueEn),
    .i_issue_addr (bus.IssueAddr),
    .i_we         (bus.WE),
    .i_wa         (bus.WA),
    .i_ra1        (bus.RA1),
    .i_ra2        (bus.RA2),
    .o_busy       (w_busy),
    .o_stall      (w_stall)
  );

  assign bus.RD1   = w_rd1;
  assign bus.RD2   = w_rd2;
  assign bus.Busy  = w_busy;
  assign bus.Stall = w_stall;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb. Each table row is one
// cycle: inputs are driven after the falling edge, combinational outputs
// are compared just before the next rising edge commits the cycle.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic clk;
  logic rst_n;

  reg_file_sb_if #(.DW(32), .AW(5)) bus ();

  reg_file_sb dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    reg_addr_t   ra1;
    reg_addr_t   ra2;
    logic        iss;
    reg_addr_t   ia;
    logic        we;
    reg_addr_t   wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [31:0] busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input reg_addr_t ra1, input reg_addr_t ra2,
                              input logic iss, input reg_addr_t ia,
                              input logic we, input reg_addr_t wa,
                              input logic [31:0] wd,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic stall, input logic [31:0] busy);
    vec_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.iss = iss; v.ia = ia;
    v.we = we; v.wa = wa; v.wd = wd;
    v.rd1 = rd1; v.rd2 = rd2; v.stall = stall; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input reg_addr_t ra1, input reg_addr_t ra2,
                       input logic iss, input reg_addr_t ia,
                       input logic we, input reg_addr_t wa,
                       input logic [31:0] wd);
    bus.RA1 = ra1; bus.RA2 = ra2;
    bus.IssueEn = iss; bus.IssueAddr = ia;
    bus.WE = we; bus.WA = wa; bus.WD = wd;
  endtask

  task automatic check_all(input string tag, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic stall,
                           input logic [31:0] busy);
    check({tag, " RD1"},   bus.RD1, rd1);
    check({tag, " RD2"},   bus.RD2, rd2);
    check({tag, " Stall"}, {31'd0, bus.Stall}, {31'd0, stall});
    check({tag, " Busy"},  bus.Busy, busy);
  endtask

  initial begin
    //           ra1 ra2 iss ia  we wa  wd            rd1           rd2           st busy
    vecs.push_back(mk(0,  0,  0, 0,  0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  0,  0, 0,  1, 0,  32'hFFFF_FFFF, 32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  0,  0, 0,  0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  7,  0, 0,  1, 7,  32'h1234_5678, 32'h0,         32'h1234_5678, 0, 32'h0));
    vecs.push_back(mk(3,  7,  0, 0,  0, 0,  32'h0,         32'h0,         32'h1234_5678, 0, 32'h0));
    vecs.push_back(mk(9,  0,  1, 9,  0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(9,  0,  0, 0,  0, 0,  32'h0,         32'h0,         32'h0,         1, 32'h0000_0200));
    vecs.push_back(mk(9,  0,  0, 0,  1, 9,  32'h5,         32'h5,         32'h0,         0, 32'h0000_0200));
    vecs.push_back(mk(9,  0,  0, 0,  0, 0,  32'h0,         32'h5,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  0,  1, 4,  0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(4,  0,  1, 4,  1, 4,  32'hAA,        32'hAA,        32'h0,         0, 32'h0000_0010));
    vecs.push_back(mk(4,  0,  0, 0,  0, 0,  32'h0,         32'hAA,        32'h0,         1, 32'h0000_0010));
    vecs.push_back(mk(0,  4,  0, 0,  1, 4,  32'hBB,        32'h0,         32'hBB,        0, 32'h0000_0010));
    vecs.push_back(mk(0,  0,  1, 0,  0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  0,  0, 0,  0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  0,  0, 0,  1, 10, 32'h77,        32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(10, 7,  0, 0,  0, 0,  32'h0,         32'h77,        32'h1234_5678, 0, 32'h0));
    vecs.push_back(mk(0,  0,  1, 12, 0, 0,  32'h0,         32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(0,  12, 1, 12, 0, 0,  32'h0,         32'h0,         32'h0,         1, 32'h0000_1000));
    vecs.push_back(mk(12, 0,  0, 0,  1, 12, 32'h1,         32'h1,         32'h0,         0, 32'h0000_1000));
    vecs.push_back(mk(12, 4,  0, 0,  0, 0,  32'h0,         32'h1,         32'hBB,        0, 32'h0));

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #3;
    check_all("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ra1, vecs[i].ra2, vecs[i].iss, vecs[i].ia,
            vecs[i].we, vecs[i].wa, vecs[i].wd);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].rd1, vecs[i].rd2,
                vecs[i].stall, vecs[i].busy);
    end

    // Mid-stream asynchronous reset discards data and pending writes
    @(negedge clk);
    drive(3, 0, 1, 15, 1, 3, 32'hDEAD_BEEF);
    #1;
    check_all("rst_pre_wr", 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive(3, 15, 0, 0, 0, 0, 32'h0);
    #1;
    check_all("rst_pre_rd", 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h0000_8000);
    #1;
    rst_n = 1'b0;
    drive(3, 15, 0, 0, 1, 3, 32'h1111_1111);
    #1;
    check_all("rst_async", 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive(3, 15, 0, 0, 0, 0, 32'h0);
    rst_n = 1'b1;
    #1;
    check_all("rst_after", 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check_all("rst_after2", 32'h0, 32'h0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_reg_file_sb
